// File: rtl/cory_rr_sel4.sv
// cory_rr_sel4: round-robin select generator for the cory 4-way mux.
//
// Watches the four source valids and issues one select token per beat on a
// valid/ready stream. Fairness is round-robin. With L > 1 a burst lock keeps
// the grant on the current source for up to L consecutive beats. An offered
// token is frozen until it is accepted.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   i_req  - [3:0] valid of mux source k on bit k
//   o_s_v  - select token valid (to mux i_s_v)
//   o_s_d  - [1:0] selected source index (to mux i_s_d)
//   i_s_r  - select token accepted (from mux o_s_r)
module cory_rr_sel4 #(
    parameter int unsigned L  = 1,
    parameter int unsigned CW = (L > 1) ? $clog2(L) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_req,
    output logic       o_s_v,
    output logic [1:0] o_s_d,
    input  logic       i_s_r
);

    localparam logic [CW-1:0] CntMax = CW'(L - 1);

    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          burst_q, burst_d;
    logic          pend_q, pend_d;
    logic [1:0]    hsel_q, hsel_d;

    logic [1:0]    search_idx;
    logic          lock;
    logic [1:0]    cand;
    logic          s_v;
    logic [1:0]    s_d;
    logic [CW-1:0] cnt_n;

    // First set bit starting at ptr+1 and ending at ptr. Walking the offsets
    // from far to near lets the nearest hit overwrite the farther ones.
    always_comb begin
        logic [1:0] idx;
        search_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr_q + 2'(i);
            if (i_req[idx]) begin
                search_idx = idx;
            end
        end
    end

    assign lock = burst_q && i_req[ptr_q] && (cnt_q < CntMax);
    assign cand = lock ? ptr_q : search_idx;

    // Token presented to the mux; a pending token ignores i_req entirely.
    always_comb begin
        if (pend_q) begin
            s_v = 1'b1;
            s_d = hsel_q;
        end else begin
            s_v = |i_req;
            s_d = (|i_req) ? cand : 2'd0;
        end
    end

    // Outputs are forced low for the whole reset assertion, independent of i_req.
    assign o_s_v = s_v & ~reset;
    assign o_s_d = reset ? 2'd0 : s_d;

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        pend_d  = pend_q;
        hsel_d  = hsel_q;
        cnt_n   = cnt_q;

        // Locked source went idle: drop the lock, rotation resumes from ptr+1.
        if (!pend_q && burst_q && !i_req[ptr_q]) begin
            burst_d = 1'b0;
            cnt_d   = '0;
        end

        if (s_v && !i_s_r) begin
            pend_d = 1'b1;
            hsel_d = s_d;
        end else if (s_v && i_s_r) begin
            pend_d = 1'b0;
            if (s_d == ptr_q && burst_q) begin
                cnt_n = (cnt_q < CntMax) ? cnt_q + CW'(1) : cnt_q;
            end else begin
                ptr_d = s_d;
                cnt_n = '0;
            end
            cnt_d   = cnt_n;
            burst_d = (L > 1) && (cnt_n < CntMax);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            burst_q <= 1'b0;
            pend_q  <= 1'b0;
            hsel_q  <= 2'd0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            pend_q  <= pend_d;
            hsel_q  <= hsel_d;
        end
    end

endmodule

// File: tb/tb_cory_rr_sel4.sv
// Bench for cory_rr_sel4: one instance with L=1, one with L=4.
// Stimulus pushes expected accepted tokens into per-instance queues; monitors
// pop and compare on every cycle the token is being accepted.
module tb_cory_rr_sel4;

    logic       clk;
    logic       reset;
    logic [3:0] req1, req4;
    logic       s_r1, s_r4;
    logic       o_s_v1, o_s_v4;
    logic [1:0] o_s_d1, o_s_d4;

    int checks   = 0;
    int failures = 0;

    logic [1:0] q1[$];
    logic [1:0] q4[$];

    cory_rr_sel4 #(.L(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .i_req (req1),
        .o_s_v (o_s_v1),
        .o_s_d (o_s_d1),
        .i_s_r (s_r1)
    );

    cory_rr_sel4 #(.L(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .i_req (req4),
        .o_s_v (o_s_v4),
        .o_s_d (o_s_d4),
        .i_s_r (s_r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a token is consumed on every cycle the mux is ready.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset && s_r1) begin
            if (q1.size() == 0) begin
                check("l1_unexpected_v", int'(o_s_v1), 0);
            end else begin
                e = q1.pop_front();
                check("l1_tok_v", int'(o_s_v1), 1);
                check("l1_tok_d", int'(o_s_d1), int'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset && s_r4) begin
            if (q4.size() == 0) begin
                check("l4_unexpected_v", int'(o_s_v4), 0);
            end else begin
                e = q4.pop_front();
                check("l4_tok_v", int'(o_s_v4), 1);
                check("l4_tok_d", int'(o_s_d4), int'(e));
            end
        end
    end

    initial begin
        reset = 1'b1;
        req1  = 4'b1111;
        req4  = 4'b1111;
        s_r1  = 1'b0;
        s_r4  = 1'b0;

        // Reset state with requests present
        @(negedge clk);
        check("rst_l1_v", int'(o_s_v1), 0);
        check("rst_l1_d", int'(o_s_d1), 0);
        check("rst_l4_v", int'(o_s_v4), 0);
        check("rst_l4_d", int'(o_s_d4), 0);
        step();
        reset = 1'b0;
        req4  = 4'b0000;

        // Pure round-robin, L=1
        for (int i = 0; i < 8; i++) q1.push_back(2'(i % 4));
        s_r1 = 1'b1;
        repeat (8) step();
        s_r1 = 1'b0;
        req1 = 4'b0000;

        // Burst lock, L=4
        req4 = 4'b1111;
        for (int i = 0; i < 16; i++) q4.push_back(2'(i / 4));
        q4.push_back(2'd0);
        s_r4 = 1'b1;
        repeat (17) step();
        s_r4 = 1'b0;
        req4 = 4'b0000;
        step();

        // Hold stability, L=1: token 2 stays offered while 0 and 1 arrive
        req1 = 4'b0100;
        @(negedge clk);
        check("hold_v", int'(o_s_v1), 1);
        check("hold_d", int'(o_s_d1), 2);
        step();
        req1 = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_v", int'(o_s_v1), 1);
            check("hold_d", int'(o_s_d1), 2);
            step();
        end
        q1.push_back(2'd2);
        q1.push_back(2'd0);
        q1.push_back(2'd1);
        s_r1 = 1'b1;
        repeat (3) step();
        s_r1 = 1'b0;
        req1 = 4'b0000;

        // Reset pulse so the burst-break run starts from ptr=3
        reset = 1'b1;
        @(negedge clk);
        check("rst2_l4_v", int'(o_s_v4), 0);
        step();
        reset = 1'b0;

        // Burst break, L=4: drop source 0 after two beats
        req4 = 4'b0011;
        q4.push_back(2'd0);
        q4.push_back(2'd0);
        s_r4 = 1'b1;
        repeat (2) step();
        req4 = 4'b0010;
        q4.push_back(2'd1);
        step();
        req4 = 4'b0011;
        q4.push_back(2'd1);
        q4.push_back(2'd1);
        q4.push_back(2'd1);
        q4.push_back(2'd0);
        repeat (4) step();
        s_r4 = 1'b0;

        // Reset mid-operation with token 2 pending
        req4 = 4'b0100;
        step();
        req4 = 4'b1111;
        req1 = 4'b1111;
        @(negedge clk);
        check("pend_l4_v", int'(o_s_v4), 1);
        check("pend_l4_d", int'(o_s_d4), 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_l4_v", int'(o_s_v4), 0);
        check("async_rst_l4_d", int'(o_s_d4), 0);
        check("async_rst_l1_v", int'(o_s_v1), 0);
        step();
        @(negedge clk);
        check("held_rst_l4_v", int'(o_s_v4), 0);
        check("held_rst_l4_d", int'(o_s_d4), 0);
        check("held_rst_l1_v", int'(o_s_v1), 0);
        step();
        reset = 1'b0;
        req1  = 4'b0000;
        q4.push_back(2'd0);
        s_r4 = 1'b1;
        step();
        s_r4 = 1'b0;
        req4 = 4'b0000;

        // Single requester on both instances
        req1 = 4'b1000;
        req4 = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            q1.push_back(2'd3);
            q4.push_back(2'd3);
        end
        s_r1 = 1'b1;
        s_r4 = 1'b1;
        repeat (6) step();
        s_r1 = 1'b0;
        s_r4 = 1'b0;
        req1 = 4'b0000;
        req4 = 4'b0000;
        repeat (2) step();

        check("l1_queue_drained", q1.size(), 0);
        check("l4_queue_drained", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
